// File: rtl/monitor_decimal_secuencial_pkg.sv
// Shared definitions for the sequential decimal monitor.
// - estado_t     : converter FSM states
// - SEG_*        : active-low 7-segment codes {dp,g,f,e,d,c,b,a}
// - cant_digitos : decimal digits needed to hold any CANT_BITS-bit magnitude
package monitor_decimal_secuencial_pkg;

   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      CONVIERTE = 2'd1,
      ACTUALIZA = 2'd2
   } estado_t;

   // Entry k is the code for decimal digit k.
   localparam logic [9:0][7:0] SEG_DIGITOS = {
      8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };
   localparam logic [7:0] SEG_BLANCO = 8'hFF;
   localparam logic [7:0] SEG_MENOS  = 8'hBF;

   // Smallest d with 10^d > 2^bits (valid for bits < 64).
   function automatic int cant_digitos(input int bits);
      longint unsigned lim;
      longint unsigned pot;
      int d;
      lim = 64'd1 << bits;
      pot = 64'd1;
      d   = 0;
      for (int k = 0; k < 20; k++) begin
         if (pot <= lim) begin
            pot = pot * 10;
            d   = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/monitor_decimal_secuencial_if.sv
// Board-side bundle of the decimal monitor.
// - switches, cargar, blanqueo_ceros : driven by the requester (master)
// - reg7SEG, sel_pantalla, ocupado   : driven by the monitor (slave)
interface monitor_decimal_secuencial_if #(
   parameter int CANT_BITS      = 8,
   parameter int CANT_PANTALLAS = 4
) ();
   logic [CANT_BITS-1:0]      switches;
   logic                      cargar;
   logic                      blanqueo_ceros;
   logic [7:0]                reg7SEG;
   logic [CANT_PANTALLAS-1:0] sel_pantalla;
   logic                      ocupado;

   modport master (
      output switches, cargar, blanqueo_ceros,
      input  reg7SEG, sel_pantalla, ocupado
   );

   modport slave (
      input  switches, cargar, blanqueo_ceros,
      output reg7SEG, sel_pantalla, ocupado
   );
endinterface

// File: rtl/monitor_decimal_secuencial_conversor_serie_bin_bcd.sv
// Serial binary-to-BCD converter (double-dabble, one bit per clock).
// Ports:
// - clock_placa, reset_placa_n : clock, async active-low reset
// - i_cargar                   : start request, ignored while busy
// - i_magnitud, i_signo        : unsigned magnitude and sign captured on start
// - o_ocupado                  : high from the edge after the start until the result lands
// - o_bcd, o_signo             : last completed result, only changes when a conversion ends
module conversor_serie_bin_bcd
   import monitor_decimal_secuencial_pkg::*;
#(
   parameter int CANT_BITS    = 8,
   parameter int CANT_NIBBLES = 4
) (
   input  logic                         clock_placa,
   input  logic                         reset_placa_n,
   input  logic                         i_cargar,
   input  logic [CANT_BITS-1:0]         i_magnitud,
   input  logic                         i_signo,
   output logic                         o_ocupado,
   output logic [CANT_NIBBLES-1:0][3:0] o_bcd,
   output logic                         o_signo
);
   localparam int W_CNT = $clog2(CANT_BITS + 1);
   localparam int W_TOT = 4 * CANT_NIBBLES + CANT_BITS;

   estado_t                      r_estado, w_estado_sig;
   logic                         w_cargar_ok, w_actualiza;
   logic [CANT_NIBBLES-1:0][3:0] r_bcd, w_bcd_aj, r_display;
   logic [CANT_BITS-1:0]         r_mag;
   logic [W_CNT-1:0]             r_cnt;
   logic                         r_signo, r_signo_disp;
   logic [W_TOT-1:0]             w_desp;

   always_ff @(posedge clock_placa or negedge reset_placa_n) begin
      if (!reset_placa_n) r_estado <= REPOSO;
      else                r_estado <= w_estado_sig;
   end

   // Busy is a pure decode of the state, so an async reset drops it immediately.
   always_comb begin
      w_estado_sig = r_estado;
      w_cargar_ok  = 1'b0;
      w_actualiza  = 1'b0;
      o_ocupado    = 1'b1;
      case (r_estado)
         REPOSO: begin
            o_ocupado = 1'b0;
            if (i_cargar) begin
               w_cargar_ok  = 1'b1;
               w_estado_sig = CONVIERTE;
            end
         end
         CONVIERTE: if (r_cnt == W_CNT'(1)) w_estado_sig = ACTUALIZA;
         ACTUALIZA: begin
            w_actualiza  = 1'b1;
            w_estado_sig = REPOSO;
         end
         default: begin
            o_ocupado    = 1'b0;
            w_estado_sig = REPOSO;
         end
      endcase
   end

   // Add-3 correction on every nibble before the shift.
   always_comb begin
      w_bcd_aj = r_bcd;
      for (int k = 0; k < CANT_NIBBLES; k++)
         if (r_bcd[k] >= 4'd5) w_bcd_aj[k] = r_bcd[k] + 4'd3;
   end

   assign w_desp = {w_bcd_aj, r_mag} << 1;

   always_ff @(posedge clock_placa or negedge reset_placa_n) begin
      if (!reset_placa_n) begin
         r_bcd        <= '0;
         r_mag        <= '0;
         r_cnt        <= '0;
         r_signo      <= 1'b0;
         r_display    <= '0;
         r_signo_disp <= 1'b0;
      end else begin
         if (w_cargar_ok) begin
            r_mag   <= i_magnitud;
            r_signo <= i_signo;
            r_bcd   <= '0;
            r_cnt   <= W_CNT'(CANT_BITS);
         end else if (r_estado == CONVIERTE) begin
            r_bcd <= w_desp[W_TOT-1:CANT_BITS];
            r_mag <= w_desp[CANT_BITS-1:0];
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_actualiza) begin
            r_display    <= r_bcd;
            r_signo_disp <= r_signo;
         end
      end
   end

   assign o_bcd   = r_display;
   assign o_signo = r_signo_disp;

endmodule

// File: rtl/monitor_decimal_secuencial.sv
// Sequential decimal monitor: captures a binary word on request, converts it
// serially to BCD and scans it onto a multiplexed bank of 7-segment displays.
// Ports:
// - clock_placa   : system clock, rising edge
// - reset_placa_n : async active-low reset
// - bus (slave)   : switches/cargar/blanqueo_ceros in, reg7SEG/sel_pantalla/ocupado out
module monitor_decimal_secuencial
   import monitor_decimal_secuencial_pkg::*;
#(
   parameter int CANT_BITS       = 8,
   parameter int CANT_PANTALLAS  = 4,
   parameter int CICLOS_REFRESCO = 50000,
   parameter int CON_SIGNO       = 0,
   parameter int ACTIVO_BAJO     = 1
) (
   input logic                    clock_placa,
   input logic                    reset_placa_n,
   monitor_decimal_secuencial_if.slave bus
);
   localparam int IW = (CANT_PANTALLAS > 1) ? $clog2(CANT_PANTALLAS) : 1;
   localparam int RW = $clog2(CICLOS_REFRESCO);

   if (CANT_PANTALLAS - CON_SIGNO < cant_digitos(CANT_BITS)) begin : g_err_pantallas
      $fatal(1, "monitor_decimal_secuencial: not enough displays for CANT_BITS");
   end
   if (CICLOS_REFRESCO < 2) begin : g_err_refresco
      $fatal(1, "monitor_decimal_secuencial: CICLOS_REFRESCO must be >= 2");
   end

   logic                           w_signo, w_signo_disp, w_ocupado;
   logic [CANT_BITS-1:0]           w_magnitud;
   logic [CANT_PANTALLAS-1:0][3:0] w_bcd;
   logic [RW-1:0]                  r_ref;
   logic [IW-1:0]                  r_idx;
   logic [CANT_PANTALLAS:0]        w_cero_desde;
   logic [CANT_PANTALLAS-1:0]      w_ceros_sup, w_sel_ah, r_sel;
   logic [3:0]                     w_nib;
   logic [7:0]                     w_codigo, r_seg;

   // Negating the most-negative value wraps to itself, which read unsigned is the right magnitude.
   assign w_signo    = (CON_SIGNO != 0) && bus.switches[CANT_BITS-1];
   assign w_magnitud = w_signo ? -bus.switches : bus.switches;

   conversor_serie_bin_bcd #(
      .CANT_BITS   (CANT_BITS),
      .CANT_NIBBLES(CANT_PANTALLAS)
   ) u_conv (
      .clock_placa  (clock_placa),
      .reset_placa_n(reset_placa_n),
      .i_cargar     (bus.cargar),
      .i_magnitud   (w_magnitud),
      .i_signo      (w_signo),
      .o_ocupado    (w_ocupado),
      .o_bcd        (w_bcd),
      .o_signo      (w_signo_disp)
   );

   assign bus.ocupado = w_ocupado;

   // Free-running refresh divider, independent of the converter.
   always_ff @(posedge clock_placa or negedge reset_placa_n) begin
      if (!reset_placa_n) begin
         r_ref <= '0;
         r_idx <= '0;
      end else if (r_ref == RW'(CICLOS_REFRESCO - 1)) begin
         r_ref <= '0;
         r_idx <= (r_idx == IW'(CANT_PANTALLAS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
         r_ref <= r_ref + 1'b1;
      end
   end

   // w_cero_desde[i]: nibble i and every nibble above it are zero.
   always_comb begin
      w_cero_desde                 = '0;
      w_cero_desde[CANT_PANTALLAS] = 1'b1;
      for (int i = CANT_PANTALLAS - 1; i >= 0; i--)
         w_cero_desde[i] = w_cero_desde[i+1] && (w_bcd[i] == 4'd0);
   end
   assign w_ceros_sup = w_cero_desde[CANT_PANTALLAS-1:0];

   always_comb begin
      w_codigo = SEG_BLANCO;
      w_nib    = w_bcd[r_idx];
      if ((CON_SIGNO != 0) && (r_idx == IW'(CANT_PANTALLAS - 1)))
         w_codigo = w_signo_disp ? SEG_MENOS : SEG_BLANCO;
      else if (bus.blanqueo_ceros && (r_idx != '0) && w_ceros_sup[r_idx])
         w_codigo = SEG_BLANCO;
      else if (w_nib <= 4'd9)
         w_codigo = SEG_DIGITOS[w_nib];
   end

   assign w_sel_ah = CANT_PANTALLAS'(1) << r_idx;

   // Segments and anode are registered together so they always switch on the same edge.
   always_ff @(posedge clock_placa or negedge reset_placa_n) begin
      if (!reset_placa_n) begin
         r_seg <= (ACTIVO_BAJO != 0) ? SEG_DIGITOS[0] : ~SEG_DIGITOS[0];
         r_sel <= (ACTIVO_BAJO != 0) ? ~CANT_PANTALLAS'(1) : CANT_PANTALLAS'(1);
      end else begin
         r_seg <= (ACTIVO_BAJO != 0) ? w_codigo : ~w_codigo;
         r_sel <= (ACTIVO_BAJO != 0) ? ~w_sel_ah : w_sel_ah;
      end
   end

   assign bus.reg7SEG      = r_seg;
   assign bus.sel_pantalla = r_sel;

endmodule
